// File: rtl/load_store_unit.sv
// Purpose: data-memory initiator for the multicycle CPU; byte/half/word loads and stores with extension and read-modify-write.
// Latency: error response 1 cycle after accept, load and word store 2 cycles, byte/half store 3 cycles.
// Backpressure: one request in flight; req_ready only when idle, response is a single-cycle pulse with no stall.
module load_store_unit #(
    parameter int dataWidth = 32,
    parameter int MEM_DEPTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [dataWidth-1:0] req_addr,
    input  logic [dataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [dataWidth-1:0] mem_adrs,
    output logic [dataWidth-1:0] mem_WD,
    output logic                 mem_WE,
    input  logic [dataWidth-1:0] mem_rData
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    localparam logic [dataWidth-3:0] DEPTH_W = (dataWidth-2)'(MEM_DEPTH);

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [1:0]           size_q, size_d;
    logic                 signed_q, signed_d;
    logic [dataWidth-1:0] addr_q, addr_d;
    logic [dataWidth-1:0] wdata_q, wdata_d;
    logic                 err_q, err_d;
    // Holds the extended load result, or the merged word for a sub-word store.
    logic [dataWidth-1:0] data_q, data_d;

    logic                 req_err;
    logic [dataWidth-1:0] word_idx;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [dataWidth-1:0] load_ext;
    logic [dataWidth-1:0] merged;

    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]))
                   | (req_addr[dataWidth-1:2] >= DEPTH_W);

    assign word_idx = {2'b00, addr_q[dataWidth-1:2]};
    assign byte_sel = mem_rData[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = mem_rData[{addr_q[1], 4'b0000} +: 16];

    // Lane extraction with sign/zero extension, and old-word merge for sub-word stores.
    always_comb begin
        load_ext = mem_rData;
        merged   = mem_rData;
        case (size_q)
            2'b00: begin
                load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_ext = mem_rData;
                merged   = mem_rData;
            end
        endcase
    end

    // Next-state and output decode; memory strobes come from the state register only.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        signed_d  = signed_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        data_d    = data_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_adrs  = '0;
        mem_WD    = '0;
        mem_WE    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    data_d   = '0;
                    state_d  = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_adrs = word_idx;
                if (!we_q) begin
                    data_d  = load_ext;
                    state_d = RESP;
                end else if (size_q == 2'b10) begin
                    mem_WD  = wdata_q;
                    mem_WE  = 1'b1;
                    state_d = RESP;
                end else begin
                    data_d  = merged;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                mem_adrs = word_idx;
                mem_WD   = data_q;
                mem_WE   = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = we_q ? '0 : data_q;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, mem_adrs, mem_WD, mem_rData;
    logic        mem_WE;

    always #5 CLK = ~CLK;

    load_store_unit #(.dataWidth(32), .MEM_DEPTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_adrs(mem_adrs), .mem_WD(mem_WD),
        .mem_WE(mem_WE), .mem_rData(mem_rData)
    );

    // dMem model: combinational read, write on posedge; preload port for setup.
    logic [31:0] mem [32];
    logic        pl_en;
    logic [4:0]  pl_idx;
    logic [31:0] pl_dat;
    always @(posedge CLK) begin
        if (mem_WE) mem[mem_adrs[4:0]] <= mem_WD;
        if (pl_en)  mem[pl_idx] <= pl_dat;
    end
    assign mem_rData = mem[mem_adrs[4:0]];

    logic [31:0] ref_mem [32];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: expected response from plain arithmetic on a word array.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err, output int lat, output int wec);
        int          nbytes, off, idx;
        logic [31:0] mask, v;
        nbytes = 1 << size;
        off    = int'(addr % 4);
        err    = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                 (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= 32);
        rd = 0; lat = 1; wec = 0;
        if (err) return;
        idx  = int'(addr / 4);
        mask = 32'hFFFF_FFFF >> (32 - 8 * nbytes);
        if (!we) begin
            v = (ref_mem[idx] >> (8 * off)) & mask;
            if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
            rd  = v;
            lat = 2;
        end else begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            lat = (nbytes == 4) ? 2 : 3;
            wec = 1;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output int lat, output int wec);
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!req_ready && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge CLK);
        #1;
        // Scramble request fields while busy: the unit must use its latched copy.
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        rd = 0; err = 0; lat = 0; wec = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (mem_WE) wec++;
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; err = rsp_err;
                break;
            end
        end
        @(negedge CLK);
        chk("rsp_pulse_one_cycle", 32'(rsp_valid), 32'd0);
        chk("rdata_zero_when_idle", rsp_rdata, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wec;
    } vec_t;

    initial begin
        vec_t        vecs[17];
        logic [31:0] rd, m_rd;
        logic        err, m_err;
        int          lat, wec, m_lat, m_wec;

        vecs[0]  = '{0, 2'd2, 0, 32'h0C, 32'h0,         32'h8899AABB, 0, 2, 0};
        vecs[1]  = '{0, 2'd0, 1, 32'h0F, 32'h0,         32'hFFFFFF88, 0, 2, 0};
        vecs[2]  = '{0, 2'd0, 0, 32'h0F, 32'h0,         32'h00000088, 0, 2, 0};
        vecs[3]  = '{0, 2'd1, 1, 32'h0E, 32'h0,         32'hFFFF8899, 0, 2, 0};
        vecs[4]  = '{0, 2'd1, 0, 32'h0C, 32'h0,         32'h0000AABB, 0, 2, 0};
        vecs[5]  = '{1, 2'd0, 0, 32'h0D, 32'h12,        32'h0,        0, 3, 1};
        vecs[6]  = '{0, 2'd2, 0, 32'h0C, 32'h0,         32'h889912BB, 0, 2, 0};
        vecs[7]  = '{1, 2'd2, 0, 32'h10, 32'hDEADBEEF,  32'h0,        0, 2, 1};
        vecs[8]  = '{0, 2'd2, 0, 32'h10, 32'h0,         32'hDEADBEEF, 0, 2, 0};
        vecs[9]  = '{0, 2'd2, 0, 32'h0E, 32'h0,         32'h0,        1, 1, 0};
        vecs[10] = '{1, 2'd1, 0, 32'h0F, 32'hFFFF,      32'h0,        1, 1, 0};
        vecs[11] = '{0, 2'd3, 0, 32'h0C, 32'h0,         32'h0,        1, 1, 0};
        vecs[12] = '{0, 2'd2, 0, 32'h80, 32'h0,         32'h0,        1, 1, 0};
        vecs[13] = '{0, 2'd2, 0, 32'h7C, 32'h0,         32'h13579BDF, 0, 2, 0};
        vecs[14] = '{0, 2'd2, 0, 32'h0C, 32'h0,         32'h889912BB, 0, 2, 0};
        vecs[15] = '{1, 2'd1, 0, 32'h0E, 32'hFFFF1234,  32'h0,        0, 3, 1};
        vecs[16] = '{0, 2'd1, 1, 32'h0E, 32'h0,         32'h00001234, 0, 2, 0};

        RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_dat = '0;

        // Preload memory while held in reset.
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            pl_en = 1'b1; pl_idx = 5'(i);
            pl_dat = (i == 3) ? 32'h8899AABB : (i == 31) ? 32'h13579BDF : $urandom;
            ref_mem[i] = pl_dat;
        end
        @(negedge CLK);
        pl_en = 1'b0;
        @(negedge CLK);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err",   32'(rsp_err), 32'd0);
        chk("reset_mem_adrs",  mem_adrs, 32'd0);
        chk("reset_mem_WD",    mem_WD, 32'd0);
        chk("reset_mem_WE",    32'(mem_WE), 32'd0);
        RST_N = 1'b1;

        // Directed vectors with hand-derived expectations.
        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                  m_rd, m_err, m_lat, m_wec);
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rd, err, lat, wec);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_we_cycles", i), 32'(wec), 32'(vecs[i].exp_wec));
        end

        // Reset during the MERGE cycle of a byte store aborts the write.
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0D; req_wdata = 32'h55;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        chk("abort_access_we", 32'(mem_WE), 32'd0);
        @(negedge CLK);
        chk("abort_merge_we", 32'(mem_WE), 32'd1);
        chk("abort_merge_adrs", mem_adrs, 32'd3);
        RST_N = 1'b0;
        #1;
        chk("abort_we_drops", 32'(mem_WE), 32'd0);
        chk("abort_wd_drops", mem_WD, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        RST_N = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_word_unchanged", mem[3], ref_mem[3]);
        model(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, m_rd, m_err, m_lat, m_wec);
        do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, rd, err, lat, wec);
        chk("post_abort_rdata", rd, m_rd);
        chk("post_abort_latency", 32'(lat), 32'(m_lat));

        // Randomized requests against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic        r_we, r_sgn;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata;
            r_we    = 1'($urandom);
            r_sgn   = 1'($urandom);
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 143));
            r_wdata = $urandom;
            model(r_we, r_size, r_sgn, r_addr, r_wdata, m_rd, m_err, m_lat, m_wec);
            do_req(r_we, r_size, r_sgn, r_addr, r_wdata, rd, err, lat, wec);
            chk("rnd_rdata", rd, m_rd);
            chk("rnd_err", 32'(err), 32'(m_err));
            chk("rnd_latency", 32'(lat), 32'(m_lat));
            chk("rnd_we_cycles", 32'(wec), 32'(m_wec));
        end

        for (int i = 0; i < 32; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
